// File: rtl/bsg_relay_piso.sv
// Width-reducing parallel-in/serial-out stage: accepts one width_p word, emits els_p beats LSB slice first.
// Optional BSG_RELAY_PISO_LAST_EN adds last_o, high on the final beat of each word.
module bsg_relay_piso #(
  parameter int width_p = 64,
  parameter int els_p   = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       v_i,
  input  logic [width_p-1:0]         data_i,
  output logic                       ready_o,
  output logic                       v_o,
  output logic [width_p/els_p-1:0]   data_o,
  input  logic                       ready_i
`ifdef BSG_RELAY_PISO_LAST_EN
  ,
  output logic                       last_o
`endif
);

  localparam int bw_lp = width_p / els_p;
  localparam int cw_lp = (els_p > 1) ? $clog2(els_p) : 1;

  generate
    if (els_p < 2 || (width_p % els_p) != 0) begin : g_bad_cfg
      $error("bsg_relay_piso: width_p must be a multiple of els_p and els_p must be >= 2");
    end
  endgenerate

  logic                 valid_q, valid_d;
  logic [width_p-1:0]   word_q,  word_d;
  logic [cw_lp-1:0]     count_q, count_d;
  logic                 last;
  logic                 in_xfer;
  logic                 out_xfer;
  logic [bw_lp-1:0]     beat_w [els_p];

  genvar gi;
  generate
    for (gi = 0; gi < els_p; gi++) begin : g_beat
      assign beat_w[gi] = word_q[gi*bw_lp +: bw_lp];
    end
  endgenerate

  assign last     = (count_q == cw_lp'(els_p - 1));
  // reset_i gates ready_o so the upstream FIFO sees no acceptance while in reset
  assign ready_o  = reset_i & (~valid_q | (ready_i & last));
  assign v_o      = valid_q;
  assign data_o   = beat_w[count_q];
  assign in_xfer  = v_i & ready_o;
  assign out_xfer = valid_q & ready_i;

`ifdef BSG_RELAY_PISO_LAST_EN
  assign last_o = valid_q & last;
`endif

  always_comb begin
    valid_d = valid_q;
    word_d  = word_q;
    count_d = count_q;
    if (!valid_q && in_xfer) begin
      valid_d = 1'b1;
      word_d  = data_i;
      count_d = '0;
    end else if (out_xfer && !last) begin
      count_d = count_q + cw_lp'(1);
    end else if (out_xfer && in_xfer) begin
      // final beat leaving while the next word arrives: reload with no bubble
      word_d  = data_i;
      count_d = '0;
    end else if (out_xfer) begin
      valid_d = 1'b0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      valid_q <= 1'b0;
      word_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      word_q  <= word_d;
      count_q <= count_d;
    end
  end

endmodule
